// File: rtl/hilo_unit.sv
// HI/LO multiply unit: a multi-cycle signed/unsigned multiplier that writes the
// 2N-bit product into HI/LO, with MTHI/MTLO moves. Define HILO_MADD_EN to accumulate.
module hilo_unit #(
  parameter int N   = 32,
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic         acc,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_q, b_q;
  logic            sgn_q;
  logic            accept, finish;
  logic [2*N-1:0]  a_ext, b_ext, product, result;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Truncating a 2N x 2N multiply of the extended operands yields the exact
  // 2N-bit product for both signed and unsigned interpretations.
  always_comb begin
    a_ext   = sgn_q ? {{N{a_q[N-1]}}, a_q} : {{N{1'b0}}, a_q};
    b_ext   = sgn_q ? {{N{b_q[N-1]}}, b_q} : {{N{1'b0}}, b_q};
    product = a_ext * b_ext;
  end

`ifdef HILO_MADD_EN
  logic acc_q;

  always_ff @(posedge clk) begin
    if (rst)         acc_q <= 1'b0;
    else if (accept) acc_q <= acc;
  end

  assign result = acc_q ? ({hi, lo} + product) : product;
`else
  logic unused_acc;
  assign unused_acc = acc;
  assign result     = product;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= signed_op;
        cnt   <= CW'(LAT - 1);
      end else if (busy && !finish) begin
        cnt <= cnt - CW'(1);
      end
      // Moves only land when the unit is idle and not being started.
      if (finish) begin
        {hi, lo} <= result;
      end else if (state == IDLE && !start) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter N, default 32, operand width in bits; HI and LO are each N bits.
REQ-002 Parameter LAT, default 4, multiply latency in cycles; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a multiply this cycle.
REQ-006 signed_op  input  1  1 = two's-complement multiply (MULT), 0 = unsigned (MULTU).
REQ-007 acc  input  1  1 = accumulate the product into {HI,LO} (meaningful only with HILO_MADD_EN).
REQ-008 A  input  N  multiplicand.
REQ-009 B  input  N  multiplier.
REQ-010 mthi  input  1  write wdata into HI.
REQ-011 mtlo  input  1  write wdata into LO.
REQ-012 wdata  input  N  data for mthi/mtlo.
REQ-013 busy  output  1  multiply in progress; the core stalls MFHI/MFLO while it is high.
REQ-014 done  output  1  one-cycle pulse: HI/LO were just loaded with a multiply result.
REQ-015 hi  output  N  HI register.
REQ-016 lo  output  N  LO register.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-018 In IDLE, start=1 at edge E0 SHALL latch A, B, signed_op and acc, load a down-counter with LAT-1, and enter BUSY.
REQ-019 busy SHALL be 1 in exactly the LAT cycles following E0 and 0 otherwise.
REQ-020 The 2N-bit product SHALL be computed from the latched operands, sign-extended when signed_op=1 and zero-extended otherwise.
REQ-021 At edge E0+LAT, hi SHALL receive product[2N-1:N], lo SHALL receive product[N-1:0], the FSM SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-022 When the cycle in which done=1 carries start=1, that start SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-023 A start while BUSY SHALL be ignored without error.
REQ-024 A change on A/B/signed_op while BUSY SHALL NOT affect the result.
REQ-025 In IDLE with start=0, mthi=1 SHALL load hi from wdata and mtlo=1 SHALL load lo from wdata at the next edge.
REQ-026 mthi and mtlo asserted together SHALL both write wdata.
REQ-027 In IDLE, start together with mthi or mtlo SHALL give priority to start and drop the move.
REQ-028 mthi/mtlo while BUSY SHALL be ignored.
REQ-029 hi/lo SHALL hold their value whenever no write applies.

Reset
REQ-030 With rst=1 at an edge, the next state SHALL be IDLE, with hi=0, lo=0, busy=0, done=0, and the counter and latched operands cleared.
REQ-031 rst SHALL take priority over every other input.
REQ-032 rst during BUSY SHALL abort the operation, with no done pulse and no HI/LO write afterwards.

Configuration
REQ-033 Macro HILO_MADD_EN SHALL control the accumulate feature.
REQ-034 With HILO_MADD_EN defined and latched acc=1, the completion write SHALL be {hi,lo} <= {hi,lo} + product, modulo 2^(2N), using the HI/LO value present at the completion edge.
REQ-035 Without HILO_MADD_EN, the acc port SHALL exist but be ignored, and every completion SHALL overwrite {hi,lo} with the product.

Verification
REQ-036 rst for 2 cycles, then idle -> hi=0, lo=0, busy=0, done=0.
REQ-037 Unsigned test: start with signed_op=0, A=0xFFFFFFFF, B=0xFFFFFFFF -> busy=1 for 4 cycles, then done pulse with hi=0xFFFFFFFE and lo=0x00000001.
REQ-038 Signed test, back-to-back: start with signed_op=1, A=0xFFFFFFFD (-3), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; start A=7, B=6 asserted in the done cycle -> busy rises immediately, and after 4 cycles lo=42 (0x2A) and hi=0.
REQ-039 Moves and collisions: in IDLE, mthi with wdata=0x12345678 -> hi=0x12345678; during BUSY, mtlo with wdata=0xDEADBEEF plus an extra start -> both ignored, and the original result is delivered.
REQ-040 Reset mid-op: start A=2, B=3, then rst=1 in the second busy cycle -> hi=lo=0, busy=0, and no done pulse for 10 cycles.
REQ-041 HILO_MADD_EN: mthi 0, mtlo 5, then start acc=1, A=2, B=3 -> hi=0, lo=0x0000000B; the same sequence without the macro -> lo=0x00000006.
